// File: rtl/spi_pkg.sv
// Shared FSM encoding for the SPI transfer sequencer.
package spi_pkg;
  localparam int STATE_W = 3;
  localparam logic [STATE_W-1:0] IDLE  = 3'd0;
  localparam logic [STATE_W-1:0] LOAD  = 3'd1;
  localparam logic [STATE_W-1:0] LEAD  = 3'd2;
  localparam logic [STATE_W-1:0] SHIFT = 3'd3;
  localparam logic [STATE_W-1:0] TRAIL = 3'd4;
endpackage

// File: rtl/spi_transfer_ctrl_if.sv
// Host-side command / tx / rx handshake bundle for the SPI sequencer.
interface spi_transfer_ctrl_if #(parameter int WordLen = 8);
  logic               start;
  logic [7:0]         num_words;
  logic [WordLen-1:0] tx_data;
  logic               tx_valid;
  logic               tx_ready;
  logic [WordLen-1:0] rx_data;
  logic               rx_valid;
  logic               busy;
  logic               done;

  modport master (output start, num_words, tx_data, tx_valid,
                  input  tx_ready, rx_data, rx_valid, busy, done);
  modport slave  (input  start, num_words, tx_data, tx_valid,
                  output tx_ready, rx_data, rx_valid, busy, done);
endinterface

// File: rtl/sclk_edge_gen.sv
// SCLK divider: toggles sclk every ClkDiv cycles while enabled and flags the
// clk cycle on which each edge is registered so the FSM can act on it.
module sclk_edge_gen #(
  parameter int ClkDiv = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic enable,
  output logic sclk,
  output logic rise_flg,
  output logic fall_flg
);
  localparam int DW = $clog2(ClkDiv + 1);

  logic [DW-1:0] div;
  logic          tick;

  assign tick     = enable && (div == DW'(ClkDiv - 1));
  assign rise_flg = tick && !sclk;
  assign fall_flg = tick && sclk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (!enable) begin
      div  <= '0;
      sclk <= 1'b0;
    end else if (tick) begin
      div  <= '0;
      sclk <= ~sclk;
    end else begin
      div  <= div + 1'b1;
    end
  end
endmodule

// File: rtl/spi_transfer_ctrl.sv
// SPI mode-0 MSB-first burst sequencer: pulls tx words, drives cs_n/sclk/mosi,
// samples miso and returns each received word with a one-cycle valid.
module spi_transfer_ctrl
  import spi_pkg::*;
#(
  parameter int WordLen = 8,
  parameter int ClkDiv  = 4,
  parameter int CsSetup = 2,
  parameter int CsHold  = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  spi_transfer_ctrl_if.slave   bus,
  output logic                 sclk,
  output logic                 mosi,
  input  logic                 miso,
  output logic                 cs_n
);
  localparam int BW = $clog2(WordLen + 1);
  localparam int CW = $clog2(((CsSetup > CsHold) ? CsSetup : CsHold) + 1);

  logic [STATE_W-1:0] state;
  logic [WordLen-1:0] sh;
  logic [BW-1:0]      bit_cnt;
  logic [CW-1:0]      cnt;
  logic [7:0]         words_left;
  logic               first;
  logic               shift_en;
  logic               rise_flg;
  logic               fall_flg;

  assign shift_en = (state == SHIFT);

  sclk_edge_gen #(.ClkDiv(ClkDiv)) u_sclk (
    .clk      (clk),
    .rst      (rst),
    .enable   (shift_en),
    .sclk     (sclk),
    .rise_flg (rise_flg),
    .fall_flg (fall_flg)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      sh           <= '0;
      bit_cnt      <= '0;
      cnt          <= '0;
      words_left   <= '0;
      first        <= 1'b0;
      mosi         <= 1'b0;
      cs_n         <= 1'b1;
      bus.tx_ready <= 1'b0;
      bus.rx_data  <= '0;
      bus.rx_valid <= 1'b0;
      bus.busy     <= 1'b0;
      bus.done     <= 1'b0;
    end else begin
      bus.tx_ready <= 1'b0;
      bus.rx_valid <= 1'b0;
      bus.done     <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            if (bus.num_words != 8'd0) begin
              words_left <= bus.num_words;
              first      <= 1'b1;
              bus.busy   <= 1'b1;
              state      <= LOAD;
            end else begin
              bus.done   <= 1'b1;
            end
          end
        end
        LOAD: begin
          // cs_n stays asserted across inter-word stalls
          if (bus.tx_valid) begin
            bus.tx_ready <= 1'b1;
            sh           <= bus.tx_data;
            mosi         <= bus.tx_data[WordLen-1];
            cs_n         <= 1'b0;
            first        <= 1'b0;
            cnt          <= '0;
            bit_cnt      <= '0;
            state        <= first ? LEAD : SHIFT;
          end
        end
        LEAD: begin
          if (cnt == CW'(CsSetup - 1)) begin
            cnt   <= '0;
            state <= SHIFT;
          end else begin
            cnt   <= cnt + 1'b1;
          end
        end
        SHIFT: begin
          if (rise_flg) begin
            sh      <= {sh[WordLen-2:0], miso};
            bit_cnt <= bit_cnt + 1'b1;
          end else if (fall_flg) begin
            if (bit_cnt < BW'(WordLen)) begin
              mosi <= sh[WordLen-1];
            end else begin
              bus.rx_data  <= sh;
              bus.rx_valid <= 1'b1;
              bit_cnt      <= '0;
              cnt          <= '0;
              words_left   <= words_left - 8'd1;
              state        <= (words_left == 8'd1) ? TRAIL : LOAD;
            end
          end
        end
        TRAIL: begin
          if (cnt == CW'(CsHold - 1)) begin
            cnt      <= '0;
            cs_n     <= 1'b1;
            bus.done <= 1'b1;
            bus.busy <= 1'b0;
            state    <= IDLE;
          end else begin
            cnt      <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_transfer_ctrl.sv
// Scoreboard bench for spi_transfer_ctrl with a behavioural SPI slave model.
module tb_spi_transfer_ctrl;
  localparam int W = 8, DIV = 4, SETUP = 2, HOLD = 2;

  logic clk = 1'b0;
  logic rst;
  logic sclk, mosi, miso, cs_n;

  spi_transfer_ctrl_if #(.WordLen(W)) bus ();

  spi_transfer_ctrl #(.WordLen(W), .ClkDiv(DIV), .CsSetup(SETUP), .CsHold(HOLD)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus.slave),
    .sclk (sclk),
    .mosi (mosi),
    .miso (miso),
    .cs_n (cs_n)
  );

  always #5 clk = ~clk;

  int n_checks = 0, n_err = 0;
  logic [W-1:0] tq[$];        // host words still to be accepted
  logic [W-1:0] slv_q[$];     // slave response words after the current one
  logic [W-1:0] exp_rx[$];    // expected rx_data sequence
  logic [W-1:0] exp_mosi[$];  // expected words seen on mosi by the slave
  bit loop_mode = 1'b0, stall = 1'b0, jitter = 1'b0;
  int done_cnt = 0, rxv_cnt = 0, txr_cnt = 0, rise_cnt = 0, cs_low = 0, cs_rise = 0;
  logic [W-1:0] slv_word = '0, mosi_word = '0;
  int bit_idx = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave: MSB-first, mosi captured on sclk rise; miso bit advances after each rise.
  assign miso = loop_mode ? mosi : slv_word[W-1-bit_idx];

  always @(posedge sclk) begin
    rise_cnt++;
    mosi_word = {mosi_word[W-2:0], mosi};
    bit_idx++;
    if (bit_idx == W) begin
      bit_idx = 0;
      check("mosi_word_expected", exp_mosi.size() != 0, 1);
      if (exp_mosi.size() != 0) check("mosi_word", mosi_word, exp_mosi.pop_front());
      if (slv_q.size() != 0) slv_word = slv_q.pop_front();
    end
  end

  always @(posedge cs_n) cs_rise++;

  // Monitor: pops expected rx words whenever rx_valid is presented.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.rx_valid) begin
        rxv_cnt++;
        check("rx_tx_overlap", bus.tx_ready, 0);
        check("rx_expected", exp_rx.size() != 0, 1);
        if (exp_rx.size() != 0) check("rx_data", bus.rx_data, exp_rx.pop_front());
      end
      if (bus.done) begin
        done_cnt++;
        check("done_busy_low", bus.busy, 0);
        check("done_cs_high", cs_n, 1);
      end
      if (bus.tx_ready) txr_cnt++;
      if (!cs_n) cs_low++;
    end
  end

  // Host tx source
  always @(negedge clk) begin
    if (bus.tx_ready && tq.size() != 0) void'(tq.pop_front());
    bus.tx_data  = (tq.size() != 0) ? tq[0] : '0;
    bus.tx_valid = (tq.size() != 0) && !stall && !(jitter && $urandom_range(0, 2) == 0);
  end

  task automatic clr();
    done_cnt = 0; rxv_cnt = 0; txr_cnt = 0; rise_cnt = 0; cs_low = 0; cs_rise = 0;
  endtask

  task automatic push_word(input logic [W-1:0] t, input logic [W-1:0] s);
    tq.push_back(t);
    exp_mosi.push_back(t);
    exp_rx.push_back(loop_mode ? t : s);
    slv_q.push_back(s);
  endtask

  task automatic pulse_start(input int n);
    @(negedge clk);
    bus.num_words = 8'(n);
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic begin_burst(input int n);
    slv_word = (slv_q.size() != 0) ? slv_q.pop_front() : '0;
    bit_idx = 0;
    pulse_start(n);
  endtask

  task automatic wait_done(input int target, input int bound);
    int i = 0;
    while (done_cnt < target && i < bound) begin
      @(negedge clk);
      i++;
    end
    check("burst_completes", done_cnt >= target, 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int i;
    bit ok;
    int n;
    bus.start = 1'b0;
    bus.num_words = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_rx_valid", bus.rx_valid, 0);
    check("rst_tx_ready", bus.tx_ready, 0);
    check("rst_rx_data", bus.rx_data, 0);
    rst = 1'b0;
    @(negedge clk);
    clr();

    // 1: single word, miso looped back
    loop_mode = 1'b1;
    push_word(8'hA5, 8'h00);
    begin_burst(1);
    wait_done(1, 400);
    check("t1_rx_count", rxv_cnt, 1);
    check("t1_done_count", done_cnt, 1);
    check("t1_cs_low_cycles", cs_low, SETUP + 2*DIV*W + HOLD);
    check("t1_sclk_rises", rise_cnt, W);
    clr();

    // 2: three words, miso held high
    loop_mode = 1'b0;
    for (int k = 0; k < 3; k++) push_word(W'($urandom), 8'hFF);
    begin_burst(3);
    wait_done(1, 1000);
    check("t2_rx_count", rxv_cnt, 3);
    check("t2_sclk_rises", rise_cnt, 24);
    check("t2_cs_single_rise", cs_rise, 1);
    check("t2_done_count", done_cnt, 1);
    check("t2_tx_accepts", txr_cnt, 3);
    clr();

    // 3: underrun before word 2
    push_word(W'($urandom), W'($urandom));
    push_word(W'($urandom), W'($urandom));
    begin_burst(2);
    i = 0;
    while (tq.size() != 1 && i < 100) begin @(negedge clk); i++; end
    stall = 1'b1;
    i = 0;
    while (rxv_cnt < 1 && i < 300) begin @(negedge clk); i++; end
    check("t3_word1_done", rxv_cnt, 1);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (sclk !== 1'b0 || cs_n !== 1'b0 || bus.busy !== 1'b1) ok = 1'b0;
    end
    check("t3_stall_pins", ok, 1);
    check("t3_no_accept_in_stall", txr_cnt, 1);
    stall = 1'b0;
    wait_done(1, 400);
    check("t3_rx_count", rxv_cnt, 2);
    check("t3_done_count", done_cnt, 1);
    clr();

    // 4: zero count
    @(negedge clk);
    bus.num_words = 8'd0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    check("t4_done_pulse", bus.done, 1);
    check("t4_busy", bus.busy, 0);
    check("t4_cs_n", cs_n, 1);
    @(negedge clk);
    check("t4_done_one_cycle", bus.done, 0);
    repeat (5) @(negedge clk);
    check("t4_no_tx_ready", txr_cnt, 0);
    check("t4_done_count", done_cnt, 1);
    check("t4_busy_idle", bus.busy, 0);
    clr();

    // 5: reset after the third sclk rise
    push_word(W'($urandom), W'($urandom));
    begin_burst(1);
    i = 0;
    while (rise_cnt < 3 && i < 200) begin @(negedge clk); i++; end
    #2 rst = 1'b1;
    #1;
    check("t5_async_cs_n", cs_n, 1);
    check("t5_async_sclk", sclk, 0);
    check("t5_async_busy", bus.busy, 0);
    @(negedge clk);
    rst = 1'b0;
    tq.delete(); slv_q.delete(); exp_rx.delete(); exp_mosi.delete();
    bit_idx = 0;
    repeat (10) @(negedge clk);
    check("t5_no_rx_valid", rxv_cnt, 0);
    check("t5_no_done", done_cnt, 0);
    clr();
    loop_mode = 1'b1;
    push_word(8'h3C, 8'h00);
    begin_burst(1);
    wait_done(1, 400);
    check("t5_after_rx_count", rxv_cnt, 1);
    clr();

    // 6: start while busy is ignored
    loop_mode = 1'b0;
    push_word(W'($urandom), W'($urandom));
    push_word(W'($urandom), W'($urandom));
    begin_burst(2);
    i = 0;
    while (rise_cnt < 4 && i < 200) begin @(negedge clk); i++; end
    pulse_start(5);
    wait_done(1, 600);
    repeat (20) @(negedge clk);
    check("t6_rx_count", rxv_cnt, 2);
    check("t6_sclk_rises", rise_cnt, 16);
    check("t6_done_count", done_cnt, 1);
    check("t6_idle_after", bus.busy, 0);
    clr();

    // randomized bursts with tx_valid jitter
    jitter = 1'b1;
    for (int k = 0; k < 8; k++) begin
      n = $urandom_range(1, 4);
      loop_mode = bit'($urandom_range(0, 1));
      for (int j = 0; j < n; j++) push_word(W'($urandom), W'($urandom));
      begin_burst(n);
      wait_done(1, 2000);
      check("rnd_rx_count", rxv_cnt, n);
      check("rnd_sclk_rises", rise_cnt, n * W);
      check("rnd_cs_single_rise", cs_rise, 1);
      check("rnd_done_count", done_cnt, 1);
      clr();
    end
    jitter = 1'b0;
    check("rx_queue_drained", exp_rx.size(), 0);
    check("mosi_queue_drained", exp_mosi.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
